// File: rtl/fitbit_display_scheduler_if.sv
// Metric-in / display-out bundle for the display scheduler; hold exists only with DISPLAY_HOLD_EN.
// Latency: none (wires only).
// Backpressure: none; the source drives levels and the scheduler samples them every cycle.
interface fitbit_display_scheduler_if;
    logic [63:0] metric_data;
    logic [3:0]  metric_valid;
`ifdef DISPLAY_HOLD_EN
    logic        hold;
`endif
    logic [15:0] disp_value;
    logic [1:0]  disp_sel;
    logic        disp_valid;
    logic        sec_tick;
    logic        rotate_pulse;

    modport master (
`ifdef DISPLAY_HOLD_EN
        output hold,
`endif
        output metric_data, metric_valid,
        input  disp_value, disp_sel, disp_valid, sec_tick, rotate_pulse
    );

    modport slave (
`ifdef DISPLAY_HOLD_EN
        input  hold,
`endif
        input  metric_data, metric_valid,
        output disp_value, disp_sel, disp_valid, sec_tick, rotate_pulse
    );
endinterface

// File: rtl/fitbit_display_scheduler.sv
// Round-robin metric display rotator with 1 s prescaler; DISPLAY_HOLD_EN adds a rotation freeze input.
// Latency: disp_sel 2 cycles after first valid, disp_value 1 cycle after disp_sel/data change.
// Backpressure: none; metric inputs are levels sampled every cycle.
module fitbit_display_scheduler #(
    parameter int CLK_HZ  = 100000000,
    parameter int DWELL_S = 2
) (
    input  logic clk100MHz,
    input  logic reset_n,
    fitbit_display_scheduler_if.slave io_disp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHOW    = 2'd1,
        ADVANCE = 2'd2
    } state_t;

    localparam int              PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [3:0]      DWELL_LAST = 4'(DWELL_S - 1);
    localparam logic [15:0]     SAT_MAX    = 16'd9999;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_dwell;
    logic [3:0]    w_dwell_nxt;
    logic [1:0]    r_sel;
    logic [1:0]    w_sel_nxt;
    logic          r_rotate;
    logic          w_rotate_nxt;
    logic          r_from_idle;
    logic          w_from_idle_nxt;
    logic [15:0]   r_value;
    logic [15:0]   w_slot;
    logic          w_tick;
    logic          w_hold;
    logic          w_found;
    logic [1:0]    w_pick;
    logic [1:0]    w_base;
    logic [1:0]    w_idx;

    assign w_tick = (r_presc == PRESC_LAST);
    assign w_slot = io_disp.metric_data[{r_sel, 4'b0000} +: 16];

`ifdef DISPLAY_HOLD_EN
    assign w_hold = io_disp.hold;
`else
    assign w_hold = 1'b0;
`endif

    always_ff @(posedge clk100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Coming out of IDLE the search starts at the held slot itself, so a
    // fresh start shows slot 0 first rather than skipping past it.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_sel;
        w_base  = r_from_idle ? r_sel : r_sel + 2'd1;
        w_idx   = w_base;
        for (int i = 0; i < 4; i++) begin
            w_idx = w_base + 2'(i);
            if (!w_found && io_disp.metric_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_ff @(posedge clk100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_dwell     <= '0;
            r_sel       <= '0;
            r_rotate    <= 1'b0;
            r_from_idle <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dwell     <= w_dwell_nxt;
            r_sel       <= w_sel_nxt;
            r_rotate    <= w_rotate_nxt;
            r_from_idle <= w_from_idle_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_dwell_nxt     = r_dwell;
        w_sel_nxt       = r_sel;
        w_rotate_nxt    = 1'b0;
        w_from_idle_nxt = r_from_idle;
        case (r_state)
            IDLE: begin
                w_dwell_nxt = '0;
                if (|io_disp.metric_valid) begin
                    w_state_nxt     = ADVANCE;
                    w_from_idle_nxt = 1'b1;
                end
            end
            SHOW: begin
                // Valid-drop outranks dwell expiry so a coincident tick yields one ADVANCE.
                if (io_disp.metric_valid == 4'b0000) begin
                    w_state_nxt = IDLE;
                end else if (!io_disp.metric_valid[r_sel]) begin
                    w_state_nxt = ADVANCE;
                    w_dwell_nxt = '0;
                end else if (w_tick && !w_hold) begin
                    if (r_dwell >= DWELL_LAST) begin
                        w_state_nxt = ADVANCE;
                        w_dwell_nxt = '0;
                    end else begin
                        w_dwell_nxt = r_dwell + 4'd1;
                    end
                end
            end
            ADVANCE: begin
                w_dwell_nxt     = '0;
                w_from_idle_nxt = 1'b0;
                if (w_found) begin
                    w_state_nxt  = SHOW;
                    w_sel_nxt    = w_pick;
                    w_rotate_nxt = (w_pick != r_sel);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_dwell_nxt     = '0;
                w_from_idle_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_value <= '0;
        end else if (r_state != IDLE) begin
            r_value <= (w_slot > SAT_MAX) ? SAT_MAX : w_slot;
        end
    end

    assign io_disp.disp_value   = r_value;
    assign io_disp.disp_sel     = r_sel;
    assign io_disp.disp_valid   = (r_state != IDLE);
    assign io_disp.sec_tick     = w_tick;
    assign io_disp.rotate_pulse = r_rotate;

endmodule

// File: tb/tb_fitbit_display_scheduler.sv
// Directed bench for fitbit_display_scheduler at CLK_HZ=10, DWELL_S=2.
module tb_fitbit_display_scheduler;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;
    int   edge_n;
    int   n_rot;
    int   n_sec;

    fitbit_display_scheduler_if bus ();

    fitbit_display_scheduler #(
        .CLK_HZ  (10),
        .DWELL_S (2)
    ) u_dut (
        .clk100MHz (clk),
        .reset_n   (rst_n),
        .io_disp   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0d, expected %0d", tag, edge_n, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
        if (bus.rotate_pulse) n_rot++;
        if (bus.sec_tick)     n_sec++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) step();
    endtask

    // Pulses reset, checks the forced-zero outputs while it is low, releases just after an edge.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_sel"},   32'(bus.disp_sel),     32'd0);
        chk({tag, "_rst_value"}, 32'(bus.disp_value),   32'd0);
        chk({tag, "_rst_valid"}, 32'(bus.disp_valid),   32'd0);
        chk({tag, "_rst_rot"},   32'(bus.rotate_pulse), 32'd0);
        chk({tag, "_rst_tick"},  32'(bus.sec_tick),     32'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        edge_n = 0;
        n_rot  = 0;
        n_sec  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        edge_n = 0;
        n_rot  = 0;
        n_sec  = 0;
        rst_n  = 1'b0;
        bus.metric_data  = {16'd42, 16'd789, 16'd456, 16'd123};
        bus.metric_valid = 4'b1111;
`ifdef DISPLAY_HOLD_EN
        bus.hold = 1'b0;
`endif

        // Start-up, first value, prescaler phase and first rotation.
        do_reset("t1");
        step();
        chk("t1_valid_e1", 32'(bus.disp_valid), 32'd1);
        step();
        chk("t1_sel_e2",   32'(bus.disp_sel),   32'd0);
        chk("t1_value_e2", 32'(bus.disp_value), 32'd123);
        run_to(8);
        chk("t1_tick_e8",  32'(bus.sec_tick),   32'd0);
        run_to(9);
        chk("t1_tick_e9",  32'(bus.sec_tick),   32'd1);
        run_to(20);
        chk("t1_sel_e20",  32'(bus.disp_sel),   32'd0);
        run_to(21);
        chk("t1_sel_e21",  32'(bus.disp_sel),   32'd1);
        chk("t1_rot_e21",  32'(bus.rotate_pulse), 32'd1);
        run_to(22);
        chk("t1_rot_e22",  32'(bus.rotate_pulse), 32'd0);
        chk("t1_value_e22", 32'(bus.disp_value), 32'd456);

        // Reset lands mid-dwell; alternate between slots 0 and 2.
        bus.metric_valid = 4'b0101;
        do_reset("t2");
        run_to(20);
        chk("t2_sel_e20", 32'(bus.disp_sel), 32'd0);
        run_to(21);
        chk("t2_sel_e21", 32'(bus.disp_sel), 32'd2);
        run_to(40);
        chk("t2_sel_e40", 32'(bus.disp_sel), 32'd2);
        run_to(41);
        chk("t2_sel_e41", 32'(bus.disp_sel), 32'd0);
        run_to(61);
        chk("t2_sel_e61", 32'(bus.disp_sel), 32'd2);
        chk("t2_rot_count", 32'(n_rot), 32'd3);
        chk("t2_tick_count", 32'(n_sec), 32'd6);

        // Saturation, and a lone valid slot never rotates.
        bus.metric_valid = 4'b0001;
        bus.metric_data[15:0] = 16'd12000;
        do_reset("t3");
        run_to(2);
        chk("t3_sat_12000", 32'(bus.disp_value), 32'd9999);
        bus.metric_data[15:0] = 16'd9999;
        step();
        chk("t3_sat_9999", 32'(bus.disp_value), 32'd9999);
        bus.metric_data[15:0] = 16'd0;
        step();
        chk("t3_sat_0", 32'(bus.disp_value), 32'd0);
        bus.metric_data[15:0] = 16'd10000;
        step();
        chk("t3_sat_10000", 32'(bus.disp_value), 32'd9999);
        bus.metric_data[15:0] = 16'd500;
        step();
        chk("t3_pass_500", 32'(bus.disp_value), 32'd500);
        run_to(35);
        chk("t3_sel_lone", 32'(bus.disp_sel), 32'd0);
        chk("t3_rot_none", 32'(n_rot), 32'd0);

        // Drop the shown slot mid-dwell; dwell must restart on slot 3.
        bus.metric_data  = {16'd42, 16'd789, 16'd456, 16'd123};
        bus.metric_valid = 4'b1111;
        do_reset("t4");
        run_to(32);
        chk("t4_sel_e32", 32'(bus.disp_sel), 32'd1);
        bus.metric_valid = 4'b1001;
        step();
        chk("t4_sel_e33", 32'(bus.disp_sel), 32'd1);
        step();
        chk("t4_sel_e34", 32'(bus.disp_sel), 32'd3);
        chk("t4_rot_e34", 32'(bus.rotate_pulse), 32'd1);
        step();
        chk("t4_value_e35", 32'(bus.disp_value), 32'd42);
        run_to(50);
        chk("t4_sel_e50", 32'(bus.disp_sel), 32'd3);
        run_to(51);
        chk("t4_sel_e51", 32'(bus.disp_sel), 32'd0);
        chk("t4_rot_count", 32'(n_rot), 32'd3);

        // IDLE entry/exit and hold-last-value behaviour.
        bus.metric_valid = 4'b0000;
        step();
        chk("t5_valid_off", 32'(bus.disp_valid), 32'd0);
        bus.metric_valid = 4'b0010;
        step();
        chk("t5_valid_on", 32'(bus.disp_valid), 32'd1);
        step();
        chk("t5_sel_1", 32'(bus.disp_sel), 32'd1);
        chk("t5_rot", 32'(bus.rotate_pulse), 32'd1);
        step();
        chk("t5_value_456", 32'(bus.disp_value), 32'd456);
        bus.metric_valid = 4'b0000;
        step();
        bus.metric_data[31:16] = 16'd999;
        step();
        step();
        step();
        chk("t5_hold_value", 32'(bus.disp_value), 32'd456);
        chk("t5_hold_sel",   32'(bus.disp_sel),   32'd1);
        chk("t5_idle_valid", 32'(bus.disp_valid), 32'd0);

`ifdef DISPLAY_HOLD_EN
        // Freeze for 50 cycles with dwell at 1; one more tick must then expire it.
        bus.metric_data  = {16'd42, 16'd789, 16'd456, 16'd123};
        bus.metric_valid = 4'b1111;
        bus.hold = 1'b0;
        do_reset("t6");
        run_to(12);
        bus.hold = 1'b1;
        run_to(62);
        chk("t6_hold_rot", 32'(n_rot), 32'd0);
        chk("t6_hold_sel", 32'(bus.disp_sel), 32'd0);
        bus.hold = 1'b0;
        run_to(70);
        chk("t6_sel_e70", 32'(bus.disp_sel), 32'd0);
        run_to(71);
        chk("t6_sel_e71", 32'(bus.disp_sel), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
